// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller bus; master drives the ID instruction fields,
// ex_branch_taken and mem_ready, slave (the controller) drives stall/flush/bubble/freeze,
// fwd_a/fwd_b, state and the CNT_W-bit stall_cnt.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic             ex_branch_taken, mem_ready;
    logic             stall_if, stall_id, flush_id, bubble_ex, freeze;
    logic [1:0]       fwd_a, fwd_b, state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rd, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread,
        output ex_branch_taken, mem_ready,
        input  stall_if, stall_id, flush_id, bubble_ex, freeze, fwd_a, fwd_b, state, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rd, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread,
        input  ex_branch_taken, mem_ready,
        output stall_if, stall_id, flush_id, bubble_ex, freeze, fwd_a, fwd_b, state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline hazard controller (load-use stall, branch flush, memory freeze, forwarding).
// Ports: clk; rst (asynchronous, active-low); bus (pipe_hazard_ctrl_if.slave) carrying the ID
// instruction fields, ex_branch_taken and mem_ready in, and stall_if, stall_id, flush_id,
// bubble_ex, freeze, fwd_a, fwd_b, state, stall_cnt out.
// Build option PIPE_HAZARD_FORWARD_EN: when defined, EX operands are forwarded from MEM/WB and
// only load-use stalls; when undefined, fwd_a/fwd_b stay 00 and any in-flight producer stalls ID.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
`ifdef PIPE_HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef enum logic [1:0] {RUN = 2'b00, HAZ = 2'b01, MWAIT = 2'b10} state_t;
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } ex_rec_t;
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } mem_rec_t;
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
    } wb_rec_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    ex_rec_t          ex;
    mem_rec_t         mem;
    wb_rec_t          wb;
    logic             ex_prod, mem_prod, wb_prod, ex_hit, mem_hit, wb_hit;
    logic             frz, br, hazard, haz_stall;
    logic [1:0]       fa, fb;

    function automatic logic reads(input logic [4:0] rd, input logic u1, input logic [4:0] rs1,
                                   input logic u2, input logic [4:0] rs2);
        return (u1 && rs1 == rd) || (u2 && rs2 == rd);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic u, input logic [4:0] rs, input logic mem_ok,
                                           input logic [4:0] mem_rd, input logic wb_ok, input logic [4:0] wb_rd);
        return !u ? 2'b00 : (mem_ok && mem_rd == rs) ? 2'b10 : (wb_ok && wb_rd == rs) ? 2'b01 : 2'b00;
    endfunction

    // x0 is hard-wired zero, so a record targeting it never produces a value.
    assign ex_prod  = ex.v & ex.rw & (ex.rd != 5'd0);
    assign mem_prod = mem.v & mem.rw & (mem.rd != 5'd0);
    assign wb_prod  = wb.v & wb.rw & (wb.rd != 5'd0);
    assign ex_hit   = ex_prod & bus.id_valid & reads(ex.rd, bus.id_use_rs1, bus.id_rs1, bus.id_use_rs2, bus.id_rs2);
    assign mem_hit  = mem_prod & bus.id_valid & reads(mem.rd, bus.id_use_rs1, bus.id_rs1, bus.id_use_rs2, bus.id_rs2);
    assign wb_hit   = wb_prod & bus.id_valid & reads(wb.rd, bus.id_use_rs1, bus.id_rs1, bus.id_use_rs2, bus.id_rs2);
    // A load in MEM has no data yet, so it is skipped and the older WB value is considered instead.
    assign fa       = FWD ? fwd_sel(ex.u1, ex.rs1, mem_prod & ~mem.mr, mem.rd, wb_prod, wb.rd) : 2'b00;
    assign fb       = FWD ? fwd_sel(ex.u2, ex.rs2, mem_prod & ~mem.mr, mem.rd, wb_prod, wb.rd) : 2'b00;
    assign hazard   = FWD ? ex_hit & ex.mr : ex_hit | mem_hit | wb_hit;

    always_comb begin
        frz           = ~bus.mem_ready;
        br            = bus.ex_branch_taken & ~frz;
        haz_stall     = hazard & ~frz & ~br;
        bus.freeze    = rst & frz;
        bus.stall_if  = rst & (frz | haz_stall);
        bus.stall_id  = rst & (frz | haz_stall);
        bus.flush_id  = rst & br;
        bus.bubble_ex = rst & (br | haz_stall);
        bus.fwd_a     = rst ? fa : 2'b00;
        bus.fwd_b     = rst ? fb : 2'b00;
        bus.state     = st;
        bus.stall_cnt = cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= RUN;
            cnt <= '0;
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            st <= frz ? MWAIT : (hazard && !bus.ex_branch_taken) ? HAZ : RUN;
            if (bus.stall_id && cnt != '1)
                cnt <= cnt + 1'b1;
            if (!frz) begin
                wb  <= '{v: mem.v, rd: mem.rd, rw: mem.rw};
                mem <= '{v: ex.v, rd: ex.rd, rw: ex.rw, mr: ex.mr};
                ex  <= (bus.bubble_ex || !bus.id_valid) ? '0 :
                       '{v: 1'b1, rd: bus.id_rd, rw: bus.id_regwrite, mr: bus.id_memread,
                         rs1: bus.id_rs1, rs2: bus.id_rs2, u1: bus.id_use_rs1, u2: bus.id_use_rs2};
            end
        end
    end
endmodule
